// File: rtl/forwarding_unit_pkg.sv
// Shared definitions for the EX-stage forwarding unit.
//   REG_ADDR_W  : default width of a register specifier
//   SEL_*       : operand-mux select codes driven on fwd_a_sel / fwd_b_sel
//   lu_state_t  : load-use hazard FSM states
package forwarding_unit_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [1:0] SEL_REGFILE = 2'b00;
    localparam logic [1:0] SEL_EXMEM   = 2'b01;
    localparam logic [1:0] SEL_MEMWB   = 2'b10;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } lu_state_t;

endpackage

// File: rtl/forwarding_unit_fwd_compare.sv
// Priority compare for one EX operand.
//   src                : source specifier of the instruction in EX (ID/EX shadow)
//   exmem_rd/exmem_wr  : destination and write-enable held in EX/MEM
//   memwb_rd/memwb_wr  : destination and write-enable held in MEM/WB
//   sel                : operand-mux select (EX/MEM beats MEM/WB; r0 never forwarded)
module fwd_compare #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] exmem_rd,
    input  logic              exmem_wr,
    input  logic [ADDR_W-1:0] memwb_rd,
    input  logic              memwb_wr,
    output logic [1:0]        sel
);
    import forwarding_unit_pkg::*;

    always_comb begin
        sel = SEL_REGFILE;
        if (exmem_wr && (exmem_rd != '0) && (exmem_rd == src)) begin
            sel = SEL_EXMEM;
        end else if (memwb_wr && (memwb_rd != '0) && (memwb_rd == src)) begin
            sel = SEL_MEMWB;
        end
    end

endmodule

// File: rtl/forwarding_unit.sv
// EX-stage forwarding and load-use stall control.
// Keeps a shadow copy of the destination fields of ID/EX, EX/MEM and MEM/WB
// and derives the operand-mux selects and the front-end stall from them.
//   clk, reset_n             : pipeline clock, asynchronous active-low reset
//   id_rs, id_rt, id_rd      : specifiers of the instruction in ID
//   id_reg_write, id_mem_read: ID instruction writes a register / is a load
//   flush                    : kill the ID instruction entering ID/EX
//   mem_stall                : freeze all internal state
//   fwd_a_sel, fwd_b_sel     : EX operand-A / operand-B mux selects
//   stall                    : hold PC and IF/ID, bubble into ID/EX
module forwarding_unit #(
    parameter int unsigned REG_ADDR_W   = forwarding_unit_pkg::REG_ADDR_W,
    parameter int unsigned LOAD_BUBBLES = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    input  logic                  mem_stall,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall
);
    import forwarding_unit_pkg::*;

    // The hazard cycle in RUN is the first bubble; the counter holds the
    // number of further bubbles still to be spent in STALL.
    localparam logic [1:0] BUBBLE_INIT = 2'(LOAD_BUBBLES - 1);

    logic [REG_ADDR_W-1:0] idex_rs, idex_rt, idex_rd;
    logic                  idex_wr, idex_mr;
    logic [REG_ADDR_W-1:0] exmem_rd, memwb_rd;
    logic                  exmem_wr, memwb_wr;

    lu_state_t state, state_next;
    logic [1:0] cnt, cnt_next;
    logic       hazard;

    fwd_compare #(.ADDR_W(REG_ADDR_W)) u_cmp_a (
        .src      (idex_rs),
        .exmem_rd (exmem_rd),
        .exmem_wr (exmem_wr),
        .memwb_rd (memwb_rd),
        .memwb_wr (memwb_wr),
        .sel      (fwd_a_sel)
    );

    fwd_compare #(.ADDR_W(REG_ADDR_W)) u_cmp_b (
        .src      (idex_rt),
        .exmem_rd (exmem_rd),
        .exmem_wr (exmem_wr),
        .memwb_rd (memwb_rd),
        .memwb_wr (memwb_wr),
        .sel      (fwd_b_sel)
    );

    always_comb begin
        hazard     = idex_mr && (idex_rd != '0) &&
                     ((idex_rd == id_rs) || (idex_rd == id_rt));
        stall      = !flush && (hazard || (state == ST_STALL));
        state_next = state;
        cnt_next   = cnt;
        if (flush) begin
            state_next = ST_RUN;
            cnt_next   = '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (hazard) begin
                        cnt_next = BUBBLE_INIT;
                        if (BUBBLE_INIT != '0) begin
                            state_next = ST_STALL;
                        end
                    end
                end
                ST_STALL: begin
                    if (cnt <= 2'd1) begin
                        state_next = ST_RUN;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt - 2'd1;
                    end
                end
                default: begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idex_rs  <= '0;
            idex_rt  <= '0;
            idex_rd  <= '0;
            idex_wr  <= 1'b0;
            idex_mr  <= 1'b0;
            exmem_rd <= '0;
            exmem_wr <= 1'b0;
            memwb_rd <= '0;
            memwb_wr <= 1'b0;
            state    <= ST_RUN;
            cnt      <= '0;
        end else if (!mem_stall) begin
            memwb_rd <= exmem_rd;
            memwb_wr <= exmem_wr;
            exmem_rd <= idex_rd;
            exmem_wr <= idex_wr;
            // Bubbles are fully cleared so a dead slot never raises a select.
            if (flush || stall) begin
                idex_rs <= '0;
                idex_rt <= '0;
                idex_rd <= '0;
                idex_wr <= 1'b0;
                idex_mr <= 1'b0;
            end else begin
                idex_rs <= id_rs;
                idex_rt <= id_rt;
                idex_rd <= id_rd;
                idex_wr <= id_reg_write;
                idex_mr <= id_mem_read;
            end
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

endmodule

// File: tb/tb_forwarding_unit.sv
// Directed bench for forwarding_unit: a cycle table on a LOAD_BUBBLES=1
// instance plus hand sequences on a LOAD_BUBBLES=2 instance.
module tb_forwarding_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_reg_write, id_mem_read, flush, mem_stall;
    logic [1:0] a1, b1, a2, b2;
    logic       s1, s2;

    always #5 clk = ~clk;

    forwarding_unit #(.REG_ADDR_W(5), .LOAD_BUBBLES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .mem_stall(mem_stall), .fwd_a_sel(a1), .fwd_b_sel(b1), .stall(s1)
    );

    forwarding_unit #(.REG_ADDR_W(5), .LOAD_BUBBLES(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .mem_stall(mem_stall), .fwd_a_sel(a2), .fwd_b_sel(b2), .stall(s2)
    );

    typedef struct packed {
        logic [4:0] rs, rt, rd;
        logic       wr, mr, fl, ms;
        logic [1:0] ea, eb;
        logic       es;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    function automatic vec_t mk(input logic [4:0] rs, rt, rd, input logic wr, mr, fl, ms,
                                input logic [1:0] ea, eb, input logic es);
        vec_t v;
        v.rs = rs; v.rt = rt; v.rd = rd; v.wr = wr; v.mr = mr; v.fl = fl; v.ms = ms;
        v.ea = ea; v.eb = eb; v.es = es;
        return v;
    endfunction

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, rt, rd, input logic wr, mr, fl, ms);
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_reg_write = wr; id_mem_read = mr; flush = fl; mem_stall = ms;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Check dut2 at the next falling edge, then advance past the rising edge.
    task automatic step2(input string tag, input logic [1:0] ea, eb, input logic es);
        @(negedge clk);
        chk({tag, "_a"}, a2, ea);
        chk({tag, "_b"}, b2, eb);
        chk({tag, "_stall"}, {1'b0, s2}, {1'b0, es});
        next_cycle();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        reset_n = 1'b1;
    endtask

    vec_t tbl[24];

    initial begin
        // rs rt rd wr mr fl ms | ea eb es  (expected = outputs during that cycle)
        tbl[0]  = mk(0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00, 0);
        tbl[1]  = mk(0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00, 0);
        tbl[2]  = mk(0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00, 0);
        tbl[3]  = mk(1, 2, 3,  1, 0, 0, 0, 2'b00, 2'b00, 0); // add r3
        tbl[4]  = mk(3, 4, 6,  1, 0, 0, 0, 2'b00, 2'b00, 0); // consumer rs=3
        tbl[5]  = mk(0, 0, 0,  0, 0, 0, 0, 2'b01, 2'b00, 0); // EX/MEM forward on A
        tbl[6]  = mk(0, 0, 3,  1, 0, 0, 0, 2'b00, 2'b00, 0); // r3 writer
        tbl[7]  = mk(1, 1, 7,  1, 0, 0, 0, 2'b00, 2'b00, 0); // independent
        tbl[8]  = mk(1, 3, 8,  1, 0, 0, 0, 2'b00, 2'b00, 0); // consumer rt=3
        tbl[9]  = mk(0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b10, 0); // MEM/WB forward on B
        tbl[10] = mk(0, 0, 3,  1, 0, 0, 0, 2'b00, 2'b00, 0); // r3 writer
        tbl[11] = mk(0, 0, 3,  1, 0, 0, 0, 2'b00, 2'b00, 0); // r3 writer again
        tbl[12] = mk(3, 3, 9,  1, 0, 0, 0, 2'b00, 2'b00, 0); // consumer rs=rt=3
        tbl[13] = mk(0, 0, 0,  0, 0, 0, 0, 2'b01, 2'b01, 0); // newest wins, A==B
        tbl[14] = mk(1, 2, 0,  1, 0, 0, 0, 2'b00, 2'b00, 0); // writer rd=0
        tbl[15] = mk(0, 0, 10, 1, 0, 0, 0, 2'b00, 2'b00, 0); // consumer rs=rt=0
        tbl[16] = mk(0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00, 0); // r0 never forwarded
        tbl[17] = mk(1, 0, 5,  1, 1, 0, 0, 2'b00, 2'b00, 0); // load r5
        tbl[18] = mk(5, 2, 11, 1, 0, 0, 0, 2'b00, 2'b00, 1); // load-use: stall
        tbl[19] = mk(5, 2, 11, 1, 0, 0, 0, 2'b00, 2'b00, 0); // consumer held, one bubble
        tbl[20] = mk(0, 0, 0,  0, 0, 0, 0, 2'b10, 2'b00, 0); // load value from MEM/WB
        tbl[21] = mk(0, 0, 6,  1, 1, 0, 0, 2'b00, 2'b00, 0); // load r6
        tbl[22] = mk(6, 0, 12, 1, 0, 1, 0, 2'b00, 2'b00, 0); // hazard + flush: no stall
        tbl[23] = mk(0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00, 0);

        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_a1", a1, 2'b00);
        chk("rst_b1", b1, 2'b00);
        chk("rst_stall1", {1'b0, s1}, 2'b00);
        chk("rst_a2", a2, 2'b00);
        chk("rst_b2", b2, 2'b00);
        chk("rst_stall2", {1'b0, s2}, 2'b00);
        next_cycle();
        reset_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].wr, tbl[i].mr, tbl[i].fl, tbl[i].ms);
            @(negedge clk);
            chk($sformatf("row%0d_a", i), a1, tbl[i].ea);
            chk($sformatf("row%0d_b", i), b1, tbl[i].eb);
            chk($sformatf("row%0d_stall", i), {1'b0, s1}, {1'b0, tbl[i].es});
            next_cycle();
        end

        // LOAD_BUBBLES=2: exactly two stall cycles.
        do_reset();
        drive(1, 0, 5, 1, 1, 0, 0);  step2("lb2_load", 2'b00, 2'b00, 0);
        drive(0, 5, 11, 1, 0, 0, 0); step2("lb2_c1", 2'b00, 2'b00, 1);
        step2("lb2_c2", 2'b00, 2'b00, 1);
        step2("lb2_c3", 2'b00, 2'b00, 0);
        drive(0, 0, 0, 0, 0, 0, 0);  step2("lb2_c4", 2'b00, 2'b00, 0);

        // mem_stall for 3 cycles inside STALL extends the stall by 3.
        do_reset();
        drive(0, 0, 7, 1, 0, 0, 0);  step2("ms_wr7", 2'b00, 2'b00, 0);
        drive(7, 0, 5, 1, 1, 0, 0);  step2("ms_load", 2'b00, 2'b00, 0);
        drive(5, 7, 11, 1, 0, 0, 0); step2("ms_haz", 2'b01, 2'b00, 1);
        drive(5, 7, 11, 1, 0, 0, 1); step2("ms_f1", 2'b00, 2'b00, 1);
        step2("ms_f2", 2'b00, 2'b00, 1);
        step2("ms_f3", 2'b00, 2'b00, 1);
        drive(5, 7, 11, 1, 0, 0, 0); step2("ms_last", 2'b00, 2'b00, 1);
        step2("ms_rel", 2'b00, 2'b00, 0);
        drive(0, 0, 0, 0, 0, 0, 0);  step2("ms_after", 2'b00, 2'b00, 0);

        // flush inside STALL drops the stall and returns to RUN.
        do_reset();
        drive(1, 0, 5, 1, 1, 0, 0);  step2("fl_load", 2'b00, 2'b00, 0);
        drive(5, 0, 11, 1, 0, 0, 0); step2("fl_haz", 2'b00, 2'b00, 1);
        drive(5, 0, 11, 1, 0, 1, 0); step2("fl_flush", 2'b00, 2'b00, 0);
        drive(0, 0, 0, 0, 0, 0, 0);  step2("fl_after", 2'b00, 2'b00, 0);

        // Asynchronous reset mid-STALL.
        do_reset();
        drive(1, 0, 5, 1, 1, 0, 0);  step2("ar_load", 2'b00, 2'b00, 0);
        drive(5, 0, 11, 1, 0, 0, 0); step2("ar_haz", 2'b00, 2'b00, 1);
        #2;
        chk("ar_in_stall", {1'b0, s2}, 2'b01);
        reset_n = 1'b0;
        #1;
        chk("ar_stall", {1'b0, s2}, 2'b00);
        chk("ar_a", a2, 2'b00);
        chk("ar_b", b2, 2'b00);
        next_cycle();
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);  step2("ar_after", 2'b00, 2'b00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
